// File: rtl/ebpf_seq_divmod.sv
// ebpf_seq_divmod: multi-cycle radix-2 restoring divider for eBPF DIV/MOD/SDIV/SMOD.
// Handles 64-bit and ALU32 forms, signed/unsigned, and eBPF divide-by-zero results.
`timescale 1ns/1ps
module ebpf_seq_divmod #(
  parameter int WIDTH     = 64,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             op_mod,
  input  logic             is_signed,
  input  logic             alu32,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] LOW32 = WIDTH'(64'h0000_0000_FFFF_FFFF);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Captured request
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             mod_q, mod_d, sgn_q, sgn_d, a32_q, a32_d;

  // Divider datapath
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;

  // Unsigned magnitude of a WIDTH or 32-bit operand; formed one bit wider so MIN negates cleanly
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is32, input logic neg);
    logic [WIDTH:0] se;
    logic [WIDTH:0] m;
    se = is32 ? (WIDTH+1)'($signed(v[31:0])) : (WIDTH+1)'($signed(v));
    if (neg) m = -se;
    else     m = is32 ? (WIDTH+1)'(v[31:0]) : {1'b0, v};
    return m[WIDTH-1:0];
  endfunction

  // Restore sign and zero-extend ALU32 results
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic neg, input logic is32);
    logic [WIDTH-1:0] r;
    r = neg ? -mag : mag;
    if (is32) r = r & LOW32;
    return r;
  endfunction

  logic             a_neg, b_neg, b_zero;
  logic [WIDTH+1:0] diff;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

  // Next-state and datapath update for each FSM phase
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    mod_d    = mod_q;
    sgn_d    = sgn_q;
    a32_d    = a32_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;

    a_neg  = sgn_q & (a32_q ? a_q[31] : a_q[WIDTH-1]);
    b_neg  = sgn_q & (a32_q ? b_q[31] : b_q[WIDTH-1]);
    b_zero = a32_q ? (b_q[31:0] == 32'd0) : (b_q == '0);
    diff   = {1'b0, rem_q, quo_q[WIDTH-1]} - {2'b00, dvs_q};

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = dividend;
          b_d     = divisor;
          mod_d   = op_mod;
          sgn_d   = SIGNED_EN ? is_signed : 1'b0;
          a32_d   = alu32;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (b_zero) begin
          // eBPF: x/0 = 0, x%0 = x
          result_d = mod_q ? apply_sign(a_q, 1'b0, a32_q) : '0;
          state_d  = S_DONE;
        end else begin
          rem_d   = '0;
          // ALU32 dividend is left-aligned so the MSB-first shift sees bit 31 first
          quo_d   = a32_q ? (magnitude(a_q, 1'b1, a_neg) << (WIDTH - 32))
                          : magnitude(a_q, 1'b0, a_neg);
          dvs_d   = magnitude(b_q, a32_q, b_neg);
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          cnt_d   = a32_q ? CW'(32) : CW'(WIDTH);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!diff[WIDTH+1]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = mod_q ? apply_sign(rem_q, rneg_q, a32_q)
                         : apply_sign(quo_q, qneg_q, a32_q);
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state is reset; operand and divider registers are plain data flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
    a_q    <= a_d;
    b_q    <= b_d;
    mod_q  <= mod_d;
    sgn_q  <= sgn_d;
    a32_q  <= a32_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvs_q  <= dvs_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

endmodule

// File: tb/tb_ebpf_seq_divmod.sv
// tb_ebpf_seq_divmod: vector table, directed handshake/reset sequences and random ops
// against an arithmetic reference model, with an expected-result queue.
`timescale 1ns/1ps
module tb_ebpf_seq_divmod;

  localparam int W = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          op_mod;
  logic          is_signed;
  logic          alu32;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;

  ebpf_seq_divmod #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .op_mod    (op_mod),
    .is_signed (is_signed),
    .alu32     (alu32),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        md;
    logic        sg;
    logic        a32;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] exp;
    int          lat;
    int          acc;
    string       name;
  } sb_t;

  sb_t  sbq[$];
  vec_t tv[20];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [63:0] b, input logic a32);
    logic z;
    z = a32 ? (b[31:0] == 32'd0) : (b == 64'd0);
    return z ? 2 : (a32 ? 35 : W + 3);
  endfunction

  function automatic logic [63:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic md, input logic sg, input logic a32);
    logic [31:0] ua, ub;
    int          sa, sb;
    longint      la, lb;
    ua = a[31:0];
    ub = b[31:0];
    if (a32) begin
      if (ub == 32'd0) return md ? {32'h0, ua} : 64'h0;
      if (sg) begin
        sa = ua;
        sb = ub;
        if (sa == int'(32'h8000_0000) && sb == -1) return md ? 64'h0 : 64'h0000_0000_8000_0000;
        return md ? {32'h0, 32'(sa % sb)} : {32'h0, 32'(sa / sb)};
      end
      return md ? {32'h0, ua % ub} : {32'h0, ua / ub};
    end
    if (b == 64'd0) return md ? a : 64'h0;
    if (sg) begin
      la = a;
      lb = b;
      if (a == MIN64 && lb == -1) return md ? 64'h0 : MIN64;
      return md ? 64'(la % lb) : 64'(la / lb);
    end
    return md ? a % b : a / b;
  endfunction

  // Present a request at a negedge, wait for acceptance, record expectation, then scramble inputs
  task automatic issue(input string nm, input logic [63:0] a, input logic [63:0] b,
                       input logic md, input logic sg, input logic a32, input logic [63:0] exp);
    int g;
    dividend  = a;
    divisor   = b;
    op_mod    = md;
    is_signed = sg;
    alu32     = a32;
    in_valid  = 1'b1;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      check({nm, " accept timeout"}, 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    sbq.push_back('{exp, exp_lat(b, a32), cyc, nm});
    @(negedge clk);
    in_valid  = 1'b0;
    dividend  = ~a;
    divisor   = {$urandom, $urandom};
    op_mod    = ~md;
    is_signed = ~sg;
    alu32     = ~a32;
  endtask

  // Wait for a result, compare against the queue head, optionally hold off out_ready
  task automatic collect(input int hold);
    int          g, first;
    sb_t         e;
    logic [63:0] r0;
    g = 0;
    while (!out_valid && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!out_valid) begin
      check("out_valid timeout", 64'(out_valid), 64'd1);
      if (sbq.size() > 0) void'(sbq.pop_front());
      return;
    end
    first = cyc;
    if (sbq.size() == 0) begin
      check("unexpected output", 64'(out_valid), 64'd0);
      return;
    end
    e = sbq.pop_front();
    check({e.name, " latency"}, 64'(first - e.acc), 64'(e.lat));
    check({e.name, " result"}, result, e.exp);
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold out_valid", 64'(out_valid), 64'd1);
      check("hold result", result, r0);
      check("hold in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({e.name, " in_ready after transfer"}, 64'(in_ready), 64'd1);
    check({e.name, " out_valid after transfer"}, 64'(out_valid), 64'd0);
  endtask

  function automatic logic [63:0] pick();
    unique case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return MIN64;
      4:       return 64'h0000_0000_8000_0000;
      5:       return 64'h0000_0000_FFFF_FFFF;
      6:       return 64'($urandom_range(0, 1000));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b, e;
    logic        md, sg, a32;
    int          seen;

    tv[0]  = '{64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14};
    tv[1]  = '{64'd100, 64'd7, 1'b1, 1'b0, 1'b0, 64'd2};
    tv[2]  = '{64'hFFFF_FFFF_0000_0010, 64'd3, 1'b1, 1'b0, 1'b1, 64'd1};
    tv[3]  = '{64'hFFFF_FFFF_0000_0010, 64'd3, 1'b0, 1'b0, 1'b1, 64'd5};
    tv[4]  = '{64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0};
    tv[5]  = '{64'h1234, 64'd0, 1'b1, 1'b0, 1'b0, 64'h1234};
    tv[6]  = '{64'hAAAA_BBBB_CCCC_DDDD, 64'd0, 1'b1, 1'b0, 1'b1, 64'h0000_0000_CCCC_DDDD};
    tv[7]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD};
    tv[8]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    tv[9]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD};
    tv[10] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0, 64'd1};
    tv[11] = '{MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, MIN64};
    tv[12] = '{MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'd0};
    tv[13] = '{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_0000};
    tv[14] = '{64'h0000_0000_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFD};
    tv[15] = '{64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF};
    tv[16] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFC};
    tv[17] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, 64'd1};
    tv[18] = '{64'd5, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1, 1'b1, 64'd5};
    tv[19] = '{64'd5, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0, 1'b0, 64'd0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    op_mod    = 1'b0;
    is_signed = 1'b0;
    alu32     = 1'b0;

    // Reset state, including a request presented while rst is high
    repeat (3) @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", result, 64'd0);
    dividend = 64'd50;
    divisor  = 64'd5;
    in_valid = 1'b1;
    @(negedge clk);
    check("rst+accept in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst+accept dropped", 64'(seen), 64'd0);
    check("in_ready after reset", 64'(in_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 20; i++) begin
      issue($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].md, tv[i].sg, tv[i].a32, tv[i].exp);
      collect(0);
    end

    // Backpressure: result held, in_valid ignored while DONE
    issue("bp", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14);
    dividend = 64'd1;
    divisor  = 64'd1;
    in_valid = 1'b1;
    collect(10);
    @(negedge clk);
    check("bp no spurious op", 64'(out_valid), 64'd0);

    // Reset in the middle of CALC discards the operation
    issue("rst_mid", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst out_valid", 64'(out_valid), 64'd0);
    check("mid rst in_ready", 64'(in_ready), 64'd0);
    check("mid rst result", result, 64'd0);
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("in_ready after mid rst", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no output after mid rst", 64'(seen), 64'd0);
    issue("post_rst", 64'd9, 64'd4, 1'b1, 1'b0, 1'b0, 64'd1);
    collect(0);

    // Random operations against the reference model
    for (int i = 0; i < 600; i++) begin
      a   = pick();
      b   = pick();
      md  = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      a32 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) a[63:32] = $urandom;
      if ($urandom_range(0, 3) == 1) b[63:32] = $urandom;
      e = ref_model(a, b, md, sg, a32);
      issue($sformatf("rnd%0d", i), a, b, md, sg, a32, e);
      collect(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
